// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM encodings for the instruction-fetch stage.
package fetch_stage_pkg;
  localparam int          PC_WIDTH  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    FS_IDLE     = 2'd0,
    FS_FETCH    = 2'd1,
    FS_DISCARD  = 2'd2,
    FS_BUFFERED = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush > stall > load > bubble.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                stall_i,
  input  logic                load_i,
  input  logic [31:0]         instr_i,
  input  logic [PC_WIDTH-1:0] pc_plus4_i,
  output logic [31:0]         instr_o,
  output logic [PC_WIDTH-1:0] pc_plus4_o,
  output logic                valid_o
);
  logic [31:0]         instr_q;
  logic [PC_WIDTH-1:0] pc_plus4_q;
  logic                valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (stall_i) begin
      instr_q    <= instr_q;
      pc_plus4_q <= pc_plus4_q;
      valid_q    <= valid_q;
    end else if (load_i) begin
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end else begin
      // no instruction this cycle: present a bubble
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem request FSM, skid buffer for stalls, IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_instr_o,
  output logic [5:0]  id_opcode_o,
  output logic [5:0]  id_funct_o,
  output logic [31:0] id_pc_plus4_o,
  output logic        id_valid_o
);
  localparam logic [PC_WIDTH-1:0] RST_PC = {RESET_PC[PC_WIDTH-1:2], 2'b00};

  fetch_state_e        state_q;
  logic [PC_WIDTH-1:0] pc_q, pend_q, skid_pc4_q;
  logic [31:0]         skid_instr_q;
  logic                skid_vld_q, req_q;

  logic [PC_WIDTH-1:0] redir_pc, pc_plus4;
  logic                ld_valid;
  logic [31:0]         ld_instr;
  logic [PC_WIDTH-1:0] ld_pc4;

  assign redir_pc = redirect_pc_i & ~32'h3;
  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32

  // A new instruction reaches IF/ID straight from memory or from the skid buffer.
  always_comb begin
    ld_valid = 1'b0;
    ld_instr = imem_rdata_i;
    ld_pc4   = pc_plus4;
    case (state_q)
      FS_FETCH:
        ld_valid = imem_ready_i && !redirect_valid_i && !stall_i;
      FS_BUFFERED: begin
        ld_valid = skid_vld_q && !redirect_valid_i && !stall_i;
        ld_instr = skid_instr_q;
        ld_pc4   = skid_pc4_q;
      end
      default: ld_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FS_IDLE;
      pc_q         <= RST_PC;
      pend_q       <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= '0;
      skid_vld_q   <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      case (state_q)
        FS_IDLE: begin
          state_q <= FS_FETCH;
          req_q   <= 1'b1;
        end
        FS_FETCH: begin
          if (imem_ready_i) begin
            if (redirect_valid_i) begin
              pc_q <= redir_pc;
            end else begin
              pc_q <= pc_plus4;
              if (stall_i) begin
                skid_instr_q <= imem_rdata_i;
                skid_pc4_q   <= pc_plus4;
                skid_vld_q   <= 1'b1;
                state_q      <= FS_BUFFERED;
                req_q        <= 1'b0;
              end
            end
          end else if (redirect_valid_i) begin
            // address must stay stable until the outstanding request completes
            pend_q  <= redir_pc;
            state_q <= FS_DISCARD;
          end
        end
        FS_DISCARD: begin
          if (imem_ready_i) begin
            pc_q    <= redirect_valid_i ? redir_pc : pend_q;
            state_q <= FS_FETCH;
          end else if (redirect_valid_i) begin
            pend_q <= redir_pc;
          end
        end
        FS_BUFFERED: begin
          if (redirect_valid_i) begin
            pc_q       <= redir_pc;
            skid_vld_q <= 1'b0;
            state_q    <= FS_FETCH;
            req_q      <= 1'b1;
          end else if (!stall_i) begin
            skid_vld_q <= 1'b0;
            state_q    <= FS_FETCH;
            req_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= FS_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;

  if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .stall_i    (stall_i),
    .load_i     (ld_valid),
    .instr_i    (ld_instr),
    .pc_plus4_i (ld_pc4),
    .instr_o    (id_instr_o),
    .pc_plus4_o (id_pc_plus4_o),
    .valid_o    (id_valid_o)
  );

  assign id_opcode_o = id_instr_o[31:26];
  assign id_funct_o  = id_instr_o[5:0];
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem returns addr|1 whenever ready is high.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] id_instr_o;
  logic [5:0]  id_opcode_o, id_funct_o;
  logic [31:0] id_pc_plus4_o;
  logic        id_valid_o;

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_ready_i     (imem_ready_i),
    .imem_rdata_i     (imem_rdata_i),
    .id_instr_o       (id_instr_o),
    .id_opcode_o      (id_opcode_o),
    .id_funct_o       (id_funct_o),
    .id_pc_plus4_o    (id_pc_plus4_o),
    .id_valid_o       (id_valid_o)
  );

  always #5 clk = ~clk;
  assign imem_rdata_i = imem_ready_i ? (imem_addr_o | 32'h1) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [31:0] instr,
                        input logic [31:0] pc4, input logic vld);
    check({tag, ".instr"}, id_instr_o, instr);
    check({tag, ".pc4"}, id_pc_plus4_o, pc4);
    check({tag, ".valid"}, {31'b0, id_valid_o}, {31'b0, vld});
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    redirect_valid_i = 1'b0; redirect_pc_i = 32'h0; imem_ready_i = 1'b1;
    #12;
    check("rst.req", {31'b0, imem_req_o}, 32'd0);
    check("rst.addr", imem_addr_o, 32'h0);
    chk_id("rst", 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;

    // streaming, zero-wait
    step();
    check("s1.req", {31'b0, imem_req_o}, 32'd1);
    check("s1.addr", imem_addr_o, 32'h0);
    check("s1.valid", {31'b0, id_valid_o}, 32'd0);
    step();
    chk_id("s2", 32'h1, 32'h4, 1'b1);
    check("s2.addr", imem_addr_o, 32'h4);
    step();
    chk_id("s3", 32'h5, 32'h8, 1'b1);
    check("s3.addr", imem_addr_o, 32'h8);

    // three wait states at address 8
    imem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ws.addr", imem_addr_o, 32'h8);
      check("ws.req", {31'b0, imem_req_o}, 32'd1);
      chk_id("ws", 32'h0, 32'h0, 1'b0);
    end
    imem_ready_i = 1'b1;
    step();
    chk_id("ws.done", 32'h9, 32'hC, 1'b1);
    check("ws.addr_next", imem_addr_o, 32'hC);

    // stall for two cycles while addr 12 returns
    stall_i = 1'b1;
    step();
    chk_id("st1", 32'h9, 32'hC, 1'b1);
    check("st1.req", {31'b0, imem_req_o}, 32'd0);
    step();
    chk_id("st2", 32'h9, 32'hC, 1'b1);
    stall_i = 1'b0;
    step();
    chk_id("st3", 32'hD, 32'h10, 1'b1);
    check("st3.addr", imem_addr_o, 32'h10);
    check("st3.req", {31'b0, imem_req_o}, 32'd1);
    step();
    chk_id("st4", 32'h11, 32'h14, 1'b1);

    // redirect with ready to reach 0x20, then redirect during a wait
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h20;
    step();
    check("rd0.addr", imem_addr_o, 32'h20);
    check("rd0.valid", {31'b0, id_valid_o}, 32'd0);
    imem_ready_i = 1'b0; redirect_pc_i = 32'h103;
    step();
    check("rd1.addr", imem_addr_o, 32'h20);
    check("rd1.req", {31'b0, imem_req_o}, 32'd1);
    redirect_valid_i = 1'b0;
    step();
    check("rd2.addr", imem_addr_o, 32'h20);
    imem_ready_i = 1'b1;
    step();
    check("rd3.addr", imem_addr_o, 32'h100);
    chk_id("rd3", 32'h0, 32'h0, 1'b0);
    step();
    chk_id("rd4", 32'h101, 32'h104, 1'b1);
    check("rd4.opcode", {26'b0, id_opcode_o}, 32'h0);
    check("rd4.funct", {26'b0, id_funct_o}, 32'h01);

    // flush and stall together: flush wins, fetched word kept in skid
    flush_i = 1'b1; stall_i = 1'b1;
    step();
    chk_id("fs", 32'h0, 32'h0, 1'b0);
    flush_i = 1'b0; stall_i = 1'b0;
    step();
    chk_id("fs.after", 32'h105, 32'h108, 1'b1);
    check("fs.addr", imem_addr_o, 32'h108);

    // PC wrap at the top of the address space
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    check("wr.addr", imem_addr_o, 32'hFFFF_FFFC);
    redirect_valid_i = 1'b0;
    step();
    chk_id("wr", 32'hFFFF_FFFD, 32'h0, 1'b1);
    check("wr.opcode", {26'b0, id_opcode_o}, 32'h3F);
    check("wr.next", imem_addr_o, 32'h0);
    step();
    chk_id("wr2", 32'h1, 32'h4, 1'b1);

    // asynchronous reset while in DISCARD
    imem_ready_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
    step();
    check("mr.addr", imem_addr_o, 32'h4);
    redirect_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mr.req", {31'b0, imem_req_o}, 32'd0);
    check("mr.addr_rst", imem_addr_o, 32'h0);
    chk_id("mr", 32'h0, 32'h0, 1'b0);
    imem_ready_i = 1'b1;
    #2 rst_n = 1'b1;
    step();
    check("mr.req1", {31'b0, imem_req_o}, 32'd1);
    check("mr.addr1", imem_addr_o, 32'h0);
    step();
    chk_id("mr.first", 32'h1, 32'h4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
